// File: rtl/data_ram_be.sv
// Byte-enabled data RAM for the single-cycle MIPS core: sub-word loads/stores,
// alignment checking and a one-word-per-cycle clear engine after reset.
module data_ram_be #(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] rd,
  output logic        busy,
  output logic        misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];
  state_t                    state;
  logic [AW-1:0]             cnt;
  logic [AW-1:0]             idx;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wlane;
  logic [NUM_LANES-1:0][7:0] word;
  logic [15:0]               half;
  logic [7:0]                byte_q;
  logic                      unused_a;

  // Upper address bits alias; only the word index and lane select matter.
  assign idx      = a[AW+1:2];
  assign unused_a = ^a[31:AW+2];
  assign busy     = (state == CLEAR);

  assign misaligned = (size == 2'b11) | ((size == 2'b01) & a[0]) |
                      ((size == 2'b10) & (a[1:0] != 2'b00));

  always_comb begin
    be = '0;
    case (size)
      2'b00:   be[a[1:0]] = 1'b1;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = '0;
    endcase
  end

  // Sub-word stores replicate the low bits so each lane sees its own copy.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    always_comb begin
      case (size)
        2'b00:   wlane[k] = wd[7:0];
        2'b01:   wlane[k] = wd[8*(k%2) +: 8];
        default: wlane[k] = wd[8*k +: 8];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
      cnt      <= cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1)) state <= IDLE;
    end else if (we && !misaligned) begin
      for (int k = 0; k < NUM_LANES; k++)
        if (be[k]) mem[idx][k] <= wlane[k];
    end
  end

  assign word   = mem[idx];
  assign half   = a[1] ? {word[3], word[2]} : {word[1], word[0]};
  assign byte_q = word[a[1:0]];

  always_comb begin
    rd = '0;
    if (!busy && !misaligned) begin
      case (size)
        2'b00:   rd = {{24{~unsigned_ld & byte_q[7]}}, byte_q};
        2'b01:   rd = {{16{~unsigned_ld & half[15]}}, half};
        2'b10:   rd = word;
        default: rd = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_data_ram_be.sv
// Directed bench for data_ram_be (DEPTH=16): clear engine, sub-word access,
// misalignment, reset mid-clear, and a no-clear instance.
module tb_data_ram_be;
  logic        clk = 1'b0;
  logic        rst, rst1, we, we1, unsigned_ld;
  logic [31:0] a, wd, rd, rd1;
  logic [1:0]  size;
  logic        busy, busy1, misaligned, misaligned1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_ram_be #(.DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .a(a), .wd(wd), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .rd(rd), .busy(busy), .misaligned(misaligned)
  );

  data_ram_be #(.DEPTH(16), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst1), .a(a), .wd(wd), .we(we1), .size(size),
    .unsigned_ld(unsigned_ld), .rd(rd1), .busy(busy1), .misaligned(misaligned1)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic w, logic [1:0] s, logic u,
                              logic [31:0] ad, logic [31:0] d,
                              logic [31:0] er, logic em);
    vec_t v;
    v.name = n; v.we = w; v.size = s; v.uns = u; v.a = ad; v.wd = d;
    v.exp_rd = er; v.exp_mis = em;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts posedges while busy, bounded so a stuck engine still terminates.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    we = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; rst1 = 1'b1; we = 1'b0; we1 = 1'b0;
    a = '0; wd = '0; size = 2'b10; unsigned_ld = 1'b0;

    // Scenario 1: clear after reset, store during busy is dropped
    tick();
    rst = 1'b0; rst1 = 1'b0;
    chk("busy_after_rst", 32'(busy), 32'd1);
    chk("nc_busy_after_rst", 32'(busy1), 32'd0);
    a = 32'h8; wd = 32'h11111111; size = 2'b10; we = 1'b1;
    count_busy(n);
    chk("clear_cycles", n, 16);
    a = 32'h8; size = 2'b10;
    #1;
    chk("lw_8_after_dropped_sw", rd, 32'h0);

    // Scenarios 2-5 and boundaries as a vector table
    vecs.push_back(mk("sw_4",        1, 2'b10, 0, 32'h04, 32'hDEADBEEF, 32'h00000000, 0));
    vecs.push_back(mk("lw_4",        0, 2'b10, 0, 32'h04, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk("lw_44_alias", 0, 2'b10, 0, 32'h44, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk("sb_5",        1, 2'b00, 0, 32'h05, 32'h123456AA, 32'hFFFFFFBE, 0));
    vecs.push_back(mk("lw_4_b",      0, 2'b10, 0, 32'h04, 32'h0,        32'hDEADAAEF, 0));
    vecs.push_back(mk("lb_5",        0, 2'b00, 0, 32'h05, 32'h0,        32'hFFFFFFAA, 0));
    vecs.push_back(mk("lbu_5",       0, 2'b00, 1, 32'h05, 32'h0,        32'h000000AA, 0));
    vecs.push_back(mk("sh_6",        1, 2'b01, 0, 32'h06, 32'h00001234, 32'hFFFFDEAD, 0));
    vecs.push_back(mk("lw_4_h",      0, 2'b10, 0, 32'h04, 32'h0,        32'h1234AAEF, 0));
    vecs.push_back(mk("lh_6",        0, 2'b01, 0, 32'h06, 32'h0,        32'h00001234, 0));
    vecs.push_back(mk("lh_4",        0, 2'b01, 0, 32'h04, 32'h0,        32'hFFFFAAEF, 0));
    vecs.push_back(mk("lhu_4",       0, 2'b01, 1, 32'h04, 32'h0,        32'h0000AAEF, 0));
    vecs.push_back(mk("lb_4",        0, 2'b00, 0, 32'h04, 32'h0,        32'hFFFFFFEF, 0));
    vecs.push_back(mk("lbu_7",       0, 2'b00, 1, 32'h07, 32'h0,        32'h00000012, 0));
    vecs.push_back(mk("sw_6_mis",    1, 2'b10, 0, 32'h06, 32'hFFFFFFFF, 32'h00000000, 1));
    vecs.push_back(mk("sh_5_mis",    1, 2'b01, 0, 32'h05, 32'hFFFFFFFF, 32'h00000000, 1));
    vecs.push_back(mk("sz11_mis",    1, 2'b11, 0, 32'h04, 32'hFFFFFFFF, 32'h00000000, 1));
    vecs.push_back(mk("lw_4_kept",   0, 2'b10, 0, 32'h04, 32'h0,        32'h1234AAEF, 0));
    vecs.push_back(mk("sb_3f_last",  1, 2'b00, 0, 32'h3F, 32'h00000080, 32'h00000000, 0));
    vecs.push_back(mk("lw_3c_last",  0, 2'b10, 0, 32'h3C, 32'h0,        32'h80000000, 0));

    foreach (vecs[i]) begin
      we = vecs[i].we; size = vecs[i].size; unsigned_ld = vecs[i].uns;
      a = vecs[i].a; wd = vecs[i].wd;
      #1;
      chk({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_mis"}, 32'(misaligned), 32'(vecs[i].exp_mis));
      if (vecs[i].we) tick();
      we = 1'b0;
    end

    // Fill every word so the second clear has something to erase
    size = 2'b10; unsigned_ld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = 32'(i * 4); wd = 32'h01010101 * (i + 1); we = 1'b1;
      tick();
    end
    we = 1'b0;

    // Scenario 6: reset reasserted during clear cycle 5
    rst = 1'b1; tick(); rst = 1'b0;
    a = 32'h4;
    #1;
    chk("rd_gated_while_busy", rd, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    count_busy(n);
    chk("clear_cycles_restart", n, 16);
    for (int i = 0; i < 16; i++) begin
      a = 32'(i * 4);
      #1;
      chk($sformatf("cleared_word_%0d", i), rd, 32'h0);
    end

    // No-clear instance: data survives reset, no writes while rst is high
    a = 32'h8; wd = 32'hCAFEF00D; size = 2'b10; we1 = 1'b1;
    tick();
    we1 = 1'b0;
    chk("nc_lw_8", rd1, 32'hCAFEF00D);
    rst1 = 1'b1; we1 = 1'b1; wd = 32'h55555555;
    tick();
    chk("nc_busy_in_rst", 32'(busy1), 32'd0);
    rst1 = 1'b0; we1 = 1'b0;
    #1;
    chk("nc_data_survives_rst", rd1, 32'hCAFEF00D);
    tick();
    chk("nc_busy_idle", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
